// File: rtl/obc_shift_accumulator.sv
// Bit-serial shift-accumulate stage for one OBC DFT output: weights each ROM slice sum by
// 2^bit_idx, adds the offset term, and hands one result downstream per accepted start.
module obc_shift_accumulator #(
   parameter int DATA_W = 8,
   parameter int ROM_W  = 32,
   parameter int ACC_W  = 48,
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ROM_W-1:0]        off_val,
   input  logic [ROM_W-1:0]        rom_in,
   output logic [IDX_W-1:0]        bit_idx,
   output logic                    m_out,
   output logic                    busy,
   output logic                    out_valid,
   output logic [ACC_W-1:0]        out_data,
   input  logic                    out_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   out_data_q, out_data_d;

   logic [ACC_W-1:0]   off_ext;
   logic [ACC_W-1:0]   rom_ext;
   logic [ACC_W-1:0]   slice_sum;
   logic               last_slice;

   assign off_ext    = {{(ACC_W-ROM_W){off_val[ROM_W-1]}}, off_val};
   assign rom_ext    = {{(ACC_W-ROM_W){rom_in[ROM_W-1]}}, rom_in};
   assign slice_sum  = acc_q + (rom_ext << bit_idx_q);
   assign last_slice = (bit_idx_q == LAST_IDX);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      bit_idx_d   = bit_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d     = off_ext;
               bit_idx_d = '0;
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = slice_sum;
            if (last_slice) begin
               bit_idx_d   = '0;
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_data_d  = slice_sum;
            end else begin
               bit_idx_d = bit_idx_q + 1'b1;
            end
         end
         DONE: begin
            // A start coinciding with the handshake launches the next conversion immediately.
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (start) begin
                  acc_d     = off_ext;
                  bit_idx_d = '0;
                  state_d   = ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         bit_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         bit_idx_q   <= bit_idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bit_idx   = bit_idx_q;
   assign m_out     = (state_q == ACCUM) && last_slice;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Scoreboard bench for obc_shift_accumulator: the driver acts as the upstream ROM stage and
// queues arithmetic reference results; a negedge monitor pops and compares on each handshake.
module tb_obc_shift_accumulator;

   localparam int DATA_W = 8;
   localparam int ROM_W  = 32;
   localparam int ACC_W  = 48;

   typedef logic [ROM_W-1:0] slices_t [DATA_W];

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [ROM_W-1:0]   off_val;
   logic [ROM_W-1:0]   rom_in;
   logic [2:0]         bit_idx;
   logic               m_out;
   logic               busy;
   logic               out_valid;
   logic [ACC_W-1:0]   out_data;
   logic               out_ready;

   int checks   = 0;
   int failures = 0;
   logic [ACC_W-1:0] exp_q [$];

   obc_shift_accumulator #(.DATA_W(DATA_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .off_val   (off_val),
      .rom_in    (rom_in),
      .bit_idx   (bit_idx),
      .m_out     (m_out),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result: offset plus each signed slice weighted by 2^i, taken modulo 2^ACC_W.
   function automatic logic [ACC_W-1:0] model(input logic [ROM_W-1:0] off, input slices_t sl);
      longint acc;
      acc = longint'($signed(off));
      for (int i = 0; i < DATA_W; i++)
         acc += longint'($signed(sl[i])) * (longint'(1) << i);
      return acc[ACC_W-1:0];
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
      check("idle_busy", busy, 0);
      check("idle_bit_idx", bit_idx, 0);
   endtask

   // Issues one conversion; must be called with the DUT in IDLE or in DONE with out_ready high.
   task automatic issue(input logic [ROM_W-1:0] off, input slices_t sl, input int pulse_at,
                        input int stall, input logic [ACC_W-1:0] exp);
      start   = 1'b1;
      off_val = off;
      rom_in  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start   = 1'b0;
      off_val = $urandom;
      if (stall > 0) out_ready = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         rom_in = sl[i];
         check("bit_idx", bit_idx, i);
         check("m_out", m_out, (i == DATA_W-1));
         check("busy_accum", busy, 1);
         if (i == pulse_at) begin
            start   = 1'b1;
            off_val = $urandom;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      exp_q.push_back(exp);
      check("out_valid_latency", out_valid, 1);
      check("m_out_done", m_out, 0);
      for (int s = 0; s < stall; s++) begin
         start   = 1'b1;
         off_val = $urandom;
         @(posedge clk); #1;
         check("out_valid_stall", out_valid, 1);
         check("busy_stall", busy, 1);
      end
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   // Monitor: compares on each handshake and checks data stays frozen while stalled.
   initial begin
      logic             held_v;
      logic [ACC_W-1:0] held_d;
      held_v = 1'b0;
      held_d = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_v = 1'b0;
         end else begin
            if (held_v) begin
               check("stall_valid_hold", out_valid, 1);
               check("stall_data_hold", out_data, held_d);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_result: got %0h with no result pending", out_data);
               end else begin
                  check("out_data", out_data, exp_q.pop_front());
               end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
         end
      end
   end

   initial begin
      slices_t sl;
      logic [ROM_W-1:0] off;
      int stall;

      rst_n     = 1'b0;
      start     = 1'b0;
      off_val   = '0;
      rom_in    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_bit_idx", bit_idx, 0);
      check("reset_m_out", m_out, 0);
      rst_n = 1'b1;
      idle(1);

      for (int i = 0; i < DATA_W; i++) sl[i] = 32'd1;
      issue(32'd0, sl, -1, 0, 48'd255);
      idle(1);

      for (int i = 0; i < DATA_W; i++) sl[i] = 32'hFFFF_FFFF;
      issue(32'd0, sl, -1, 0, 48'hFFFF_FFFF_FF01);
      idle(2);

      for (int i = 0; i < DATA_W; i++) sl[i] = 32'd0;
      issue(32'd100, sl, -1, 0, 48'd100);
      for (int i = 0; i < DATA_W; i++) sl[i] = 32'h7FFF_FFFF;
      issue(32'hFFFF_FFFF, sl, -1, 5, 48'd547608329984);

      for (int i = 0; i < DATA_W; i++) sl[i] = 32'd3 << i;
      issue(32'd7, sl, -1, 0, model(32'd7, sl));
      issue(32'd7, sl, 4, 0, model(32'd7, sl));
      idle(1);

      start   = 1'b1;
      off_val = 32'd55;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rom_in = 32'h1234;
         if (i == 3) rst_n = 1'b0;
         @(posedge clk); #1;
      end
      check("midreset_busy", busy, 0);
      check("midreset_out_valid", out_valid, 0);
      check("midreset_bit_idx", bit_idx, 0);
      rst_n = 1'b1;
      for (int i = 0; i < DATA_W; i++) sl[i] = 32'd1 << i;
      issue(32'd5, sl, -1, 0, model(32'd5, sl));
      idle(1);

      for (int n = 0; n < 40; n++) begin
         off = $urandom;
         for (int i = 0; i < DATA_W; i++) begin
            case ($urandom_range(0, 3))
               0:       sl[i] = 32'h8000_0000;
               1:       sl[i] = 32'h7FFF_FFFF;
               default: sl[i] = $urandom;
            endcase
         end
         stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
         issue(off, sl, ($urandom_range(0, 3) == 0) ? $urandom_range(0, DATA_W-1) : -1,
               stall, model(off, sl));
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      end

      for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: got %0d results still pending, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
